ioctl_rom_loader: RTL and testbench

IOCTL_ROM_LOADER -- requirements
Module: ioctl_rom_loader

---
 rtl/ioctl_rom_loader.sv | 242 ++++++++++++++++++++++++
 tb/tb_ioctl_rom_loader.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_rom_loader.sv
// Packs a byte-wide ioctl download stream into 16-bit word writes with byte enables.
// Optional macro LOADER_CHECKSUM_EN adds a per-session 16-bit byte checksum output.
module ioctl_rom_loader #(
    parameter int         ADDR_W = 23,
    parameter logic [7:0] INDEX  = 8'd0
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [7:0]        ioctl_index,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    output logic [1:0]        mem_be,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              err,
`ifdef LOADER_CHECKSUM_EN
    output logic [15:0]       checksum,
`endif
    output logic [2:0]        state_dbg
);

    // Memory handshake: mem_req rises with stable addr/din/be and holds until
    // mem_ack is sampled high; ioctl_wait mirrors mem_req so the host stalls.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
        S_FLUSH   = 3'd3,
        S_FIN     = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                dl_q, dl_d;
    logic                pend_q, pend_d;
    logic [7:0]          pend_byte_q, pend_byte_d;
    logic [ADDR_W-1:0]   pend_word_q, pend_word_d;
    logic                hold_q, hold_d;
    logic [7:0]          hold_byte_q, hold_byte_d;
    logic [ADDR_W-1:0]   hold_word_q, hold_word_d;
    logic                flush_q, flush_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [15:0]         mem_din_q, mem_din_d;
    logic [1:0]          mem_be_q, mem_be_d;
    logic                err_q, err_d;

    logic [ADDR_W-1:0]   wr_word;
    logic                dl_rise, dl_fall, claim;

    assign wr_word = ioctl_addr[ADDR_W:1];
    assign dl_rise = ioctl_download & ~dl_q;
    assign dl_fall = ~ioctl_download & dl_q;
    assign claim   = (state_q == S_IDLE) && dl_rise && (ioctl_index == INDEX);

    if (ADDR_W < 24) begin : g_unused_addr
        logic unused_addr_bits;
        assign unused_addr_bits = ^ioctl_addr[24:ADDR_W+1];
    end

    always_comb begin
        state_d     = state_q;
        dl_d        = ioctl_download;
        pend_d      = pend_q;
        pend_byte_d = pend_byte_q;
        pend_word_d = pend_word_q;
        hold_d      = hold_q;
        hold_byte_d = hold_byte_q;
        hold_word_d = hold_word_q;
        flush_d     = flush_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_be_d    = mem_be_q;
        err_d       = err_q;

        if (ioctl_wr && mem_req_q) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (claim) begin
                    state_d = S_COLLECT;
                    err_d   = 1'b0;
                    pend_d  = 1'b0;
                    hold_d  = 1'b0;
                    flush_d = 1'b0;
                end
            end
            S_COLLECT: begin
                if (ioctl_wr) begin
                    if (!ioctl_addr[0]) begin
                        // A stale low byte from another word goes out on its own.
                        if (pend_q && (pend_word_q != wr_word)) begin
                            mem_req_d  = 1'b1;
                            mem_addr_d = pend_word_q;
                            mem_din_d  = {8'h00, pend_byte_q};
                            mem_be_d   = 2'b01;
                            state_d    = S_WRITE;
                        end
                        pend_d      = 1'b1;
                        pend_byte_d = ioctl_dout;
                        pend_word_d = wr_word;
                    end else if (pend_q && (pend_word_q == wr_word)) begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = wr_word;
                        mem_din_d  = {ioctl_dout, pend_byte_q};
                        mem_be_d   = 2'b11;
                        pend_d     = 1'b0;
                        state_d    = S_WRITE;
                    end else if (pend_q) begin
                        // Two writes needed: stale low byte now, this high byte queued.
                        mem_req_d   = 1'b1;
                        mem_addr_d  = pend_word_q;
                        mem_din_d   = {8'h00, pend_byte_q};
                        mem_be_d    = 2'b01;
                        pend_d      = 1'b0;
                        hold_d      = 1'b1;
                        hold_byte_d = ioctl_dout;
                        hold_word_d = wr_word;
                        state_d     = S_WRITE;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = wr_word;
                        mem_din_d  = {ioctl_dout, 8'h00};
                        mem_be_d   = 2'b10;
                        state_d    = S_WRITE;
                    end
                end
                if (dl_fall) begin
                    if (state_d == S_WRITE) flush_d = 1'b1;
                    else                    state_d = S_FLUSH;
                end
            end
            S_WRITE: begin
                if (dl_fall) flush_d = 1'b1;
                if (mem_ack) begin
                    if (hold_q) begin
                        mem_addr_d = hold_word_q;
                        mem_din_d  = {hold_byte_q, 8'h00};
                        mem_be_d   = 2'b10;
                        hold_d     = 1'b0;
                    end else begin
                        mem_req_d = 1'b0;
                        state_d   = (flush_q || dl_fall) ? S_FLUSH : S_COLLECT;
                    end
                end
            end
            S_FLUSH: begin
                flush_d = 1'b1;
                if (pend_q) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = pend_word_q;
                    mem_din_d  = {8'h00, pend_byte_q};
                    mem_be_d   = 2'b01;
                    pend_d     = 1'b0;
                    state_d    = S_WRITE;
                end else begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                flush_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // dl_q resets high so a download already running at release is never seen as rising.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            dl_q        <= 1'b1;
            pend_q      <= 1'b0;
            pend_byte_q <= 8'h00;
            pend_word_q <= '0;
            hold_q      <= 1'b0;
            hold_byte_q <= 8'h00;
            hold_word_q <= '0;
            flush_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= 16'h0000;
            mem_be_q    <= 2'b00;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dl_q        <= dl_d;
            pend_q      <= pend_d;
            pend_byte_q <= pend_byte_d;
            pend_word_q <= pend_word_d;
            hold_q      <= hold_d;
            hold_byte_q <= hold_byte_d;
            hold_word_q <= hold_word_d;
            flush_q     <= flush_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_be_q    <= mem_be_d;
            err_q       <= err_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (claim) begin
            csum_d = 16'h0000;
        end else if ((state_q == S_COLLECT) && ioctl_wr) begin
            csum_d = csum_q + {8'h00, ioctl_dout};
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) csum_q <= 16'h0000;
        else          csum_q <= csum_d;
    end

    assign checksum = csum_q;
`endif

    assign mem_req    = mem_req_q;
    assign ioctl_wait = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign mem_be     = mem_be_q;
    assign err        = err_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_FIN);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_ioctl_rom_loader.sv
// Directed plus randomized sessions against a byte-image memory model of ioctl_rom_loader.
module tb_ioctl_rom_loader;
  localparam int ADDR_W = 23;

  logic              clk_sys = 1'b0;
  logic              reset_n = 1'b0;
  logic              ioctl_download = 1'b0;
  logic              ioctl_wr = 1'b0;
  logic [24:0]       ioctl_addr = '0;
  logic [7:0]        ioctl_dout = 8'h00;
  logic [7:0]        ioctl_index = 8'h00;
  logic              ioctl_wait;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_din;
  logic [1:0]        mem_be;
  logic              mem_req;
  logic              mem_ack;
  logic              busy, done, err;
  logic [2:0]        state_dbg;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0]       checksum;
`endif

  logic resp_ack = 1'b0;
  logic stray_ack = 1'b0;
  assign mem_ack = resp_ack | stray_ack;

  int checks = 0;
  int errors = 0;
  int ack_lat = 1;
  int wait_cyc = 0, req_cyc = 0, busy_cyc = 0, done_cyc = 0;
  logic [40:0] obs_q[$];
  logic [40:0] exp_q[$];
  logic [7:0]  exp_img[64];
  logic [7:0]  obs_img[64];
  logic [15:0] cs_at_done = 16'h0000;

  ioctl_rom_loader #(.ADDR_W(ADDR_W), .INDEX(8'd0)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_be(mem_be), .mem_req(mem_req), .mem_ack(mem_ack),
    .busy(busy), .done(done), .err(err),
`ifdef LOADER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .state_dbg(state_dbg)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks after ack_lat cycles of mem_req, records writes into obs_img.
  int age = 0;
  logic req_seen = 1'b0;
  logic [40:0] rec = '0;
  always @(negedge clk_sys) begin
    if (ioctl_wait) wait_cyc++;
    if (mem_req) req_cyc++;
    if (busy) busy_cyc++;
    if (done) done_cyc++;
    check("wait_tracks_req", 64'(ioctl_wait), 64'(mem_req));
    if (resp_ack) begin
      resp_ack = 1'b0;
      req_seen = 1'b0;
      age = 0;
    end else if (mem_req) begin
      if (!req_seen) begin
        rec = {mem_addr, mem_din, mem_be};
        req_seen = 1'b1;
      end else begin
        check("req_stable", 64'({mem_addr, mem_din, mem_be}), 64'(rec));
      end
      if (age >= ack_lat) begin
        int wa;
        resp_ack = 1'b1;
        obs_q.push_back(rec);
        wa = int'(rec[40:18]);
        if (wa < 32) begin
          if (rec[0]) obs_img[2*wa]   = rec[9:2];
          if (rec[1]) obs_img[2*wa+1] = rec[17:10];
        end
      end else begin
        age++;
      end
    end else begin
      req_seen = 1'b0;
      age = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic send_byte(input int a, input logic [7:0] d);
    int n = 0;
    while (ioctl_wait && n < 100) begin
      tick(1);
      n++;
    end
    check("host_wait_bound", 64'(n < 100), 64'd1);
    ioctl_addr = 25'(a);
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    tick(1);
    ioctl_wr = 1'b0;
  endtask

  task automatic start_session(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    tick(1);
  endtask

  task automatic end_session();
    int n = 0;
    ioctl_download = 1'b0;
    tick(1);
    while (busy && n < 200) begin
`ifdef LOADER_CHECKSUM_EN
      if (done) cs_at_done = checksum;
`endif
      tick(1);
      n++;
    end
    check("session_end_bound", 64'(n < 200), 64'd1);
  endtask

  task automatic clear_sb();
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      exp_img[i] = 8'hEE;
      obs_img[i] = 8'hEE;
    end
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, "_word"}, 64'(obs_q[i]), 64'(exp_q[i]));
  endtask

  task automatic random_session();
    int a, len, diffs, d0;
    logic [7:0] d;
    logic [31:0] words;
    logic [15:0] sum;
    clear_sb();
    words = '0;
    sum = 16'h0000;
    ack_lat = $urandom_range(0, 3);
    d0 = done_cyc;
    start_session(8'd0);
    tick($urandom_range(0, 2));
    a = $urandom_range(0, 7);
    len = $urandom_range(1, 12);
    for (int i = 0; i < len; i++) begin
      d = 8'($urandom);
      exp_img[a] = d;
      words[a/2] = 1'b1;
      sum = sum + 16'(d);
      send_byte(a, d);
      tick($urandom_range(0, 2));
      a = a + (($urandom_range(0, 3) == 0) ? 2 : 1);
    end
    end_session();
    diffs = 0;
    for (int i = 0; i < 64; i++)
      if (obs_img[i] !== exp_img[i]) diffs++;
    check("rand_write_count", 64'(obs_q.size()), 64'($countones(words)));
    check("rand_image_diffs", 64'(diffs), 64'd0);
    check("rand_done_pulses", 64'(done_cyc - d0), 64'd1);
    check("rand_err", 64'(err), 64'd0);
`ifdef LOADER_CHECKSUM_EN
    check("rand_checksum", 64'(cs_at_done), 64'(sum));
`endif
  endtask

  initial begin
    int w0, d0, r0, b0;
    clear_sb();
    tick(2);
    check("reset_outputs", 64'({mem_req, ioctl_wait, busy, done, err, mem_be, mem_din, mem_addr}), 64'd0);
    check("reset_state", 64'(state_dbg), 64'd0);
    reset_n = 1'b1;
    tick(2);

    // Full word at 0/1 with ack one cycle after request; stray ack beforehand.
    clear_sb();
    ack_lat = 1;
    w0 = wait_cyc;
    d0 = done_cyc;
    start_session(8'd0);
    check("claimed_busy", 64'(busy), 64'd1);
    stray_ack = 1'b1;
    tick(1);
    stray_ack = 1'b0;
    check("stray_ack_no_req", 64'(mem_req), 64'd0);
    send_byte(0, 8'h11);
    send_byte(1, 8'h22);
    tick(4);
    exp_q.push_back({23'd0, 16'h2211, 2'b11});
    compare_writes("pair");
    check("pair_wait_cycles", 64'(wait_cyc - w0), 64'd2);
    end_session();
    check("pair_done_pulses", 64'(done_cyc - d0), 64'd1);
    check("pair_idle_after", 64'(busy), 64'd0);

    // Lone low byte flushed on download fall.
    clear_sb();
    d0 = done_cyc;
    start_session(8'd0);
    send_byte(4, 8'hAB);
    tick(2);
    check("lone_no_early_write", 64'(obs_q.size()), 64'd0);
    end_session();
    exp_q.push_back({23'd2, 16'h00AB, 2'b01});
    compare_writes("lone");
    check("lone_done_pulses", 64'(done_cyc - d0), 64'd1);

    // Foreign index session is ignored entirely.
    clear_sb();
    r0 = req_cyc; b0 = busy_cyc; d0 = done_cyc;
    start_session(8'd1);
    for (int i = 0; i < 4; i++) send_byte(i, 8'(8'h40 + i));
    end_session();
    check("foreign_req", 64'(req_cyc - r0), 64'd0);
    check("foreign_busy", 64'(busy_cyc - b0), 64'd0);
    check("foreign_done", 64'(done_cyc - d0), 64'd0);
    check("foreign_writes", 64'(obs_q.size()), 64'd0);

    // Byte during a stalled write is dropped and flagged.
    clear_sb();
    ack_lat = 5;
    d0 = done_cyc;
    start_session(8'd0);
    send_byte(0, 8'h10);
    send_byte(1, 8'h20);
    tick(1);
    check("stall_wait_high", 64'(ioctl_wait), 64'd1);
    ioctl_addr = 25'd2;
    ioctl_dout = 8'h33;
    ioctl_wr = 1'b1;
    tick(1);
    ioctl_wr = 1'b0;
    check("stall_err_set", 64'(err), 64'd1);
    end_session();
    exp_q.push_back({23'd0, 16'h2010, 2'b11});
    compare_writes("stall");
    check("stall_err_sticky", 64'(err), 64'd1);
    check("stall_done_pulses", 64'(done_cyc - d0), 64'd1);
    ack_lat = 1;
    start_session(8'd0);
    check("err_cleared_on_claim", 64'(err), 64'd0);
    end_session();

    // Reset while a write is outstanding; session stays unclaimed after release.
    clear_sb();
    ack_lat = 20;
    start_session(8'd0);
    send_byte(0, 8'h01);
    send_byte(1, 8'h02);
    check("rst_req_before", 64'(mem_req), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_drops_req", 64'({mem_req, ioctl_wait, busy}), 64'd0);
    tick(3);
    reset_n = 1'b1;
    r0 = req_cyc; b0 = busy_cyc;
    tick(2);
    send_byte(2, 8'h03);
    send_byte(3, 8'h04);
    send_byte(4, 8'h05);
    tick(3);
    check("rst_unclaimed_busy", 64'(busy_cyc - b0), 64'd0);
    check("rst_unclaimed_req", 64'(req_cyc - r0), 64'd0);
    compare_writes("rst");
    ioctl_download = 1'b0;
    tick(3);
    ack_lat = 1;

    for (int s = 0; s < 8; s++) random_session();

`ifdef LOADER_CHECKSUM_EN
    clear_sb();
    start_session(8'd0);
    send_byte(0, 8'hFF);
    send_byte(1, 8'hFF);
    send_byte(2, 8'h03);
    end_session();
    check("checksum_ff_ff_03", 64'(cs_at_done), 64'h0201);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
